// File: rtl/rgb_to_yuv_packer.sv
// rgb_to_yuv_packer: converts RGB888 pixel pairs into the 4:2:2 byte stream U, Y1, V, Y2.
module rgb_to_yuv_packer #(
  parameter int Y_CR = 74,
  parameter int Y_CG = 162,
  parameter int Y_CB = 20,
  parameter int V_C  = 158
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_en,
  input  logic [23:0] rgb_in,
  output logic        busy,
  output logic        out_valid,
  output logic [7:0]  yuv_out
);
  typedef enum logic [2:0] {IDLE, HAVE0, OUT_U, OUT_Y1, OUT_V, OUT_Y2} state_t;
  localparam logic signed [17:0] VC18 = 18'(V_C);
  state_t state, nxt;
  logic cap0, cap1;
  logic [7:0] r, g, b, y, y0, y1, u, v, u_sat, v_sat;
  logic [15:0] ys;
  logic signed [9:0] d, e, ud;
  logic signed [17:0] e18, ud18, p;
  function automatic logic [7:0] sat(input logic signed [17:0] x);
    return x > 18'sd127 ? 8'h7f : x < -18'sd128 ? 8'h80 : x[7:0];
  endfunction
  assign {r, g, b} = rgb_in;
  assign ys = 16'(Y_CR * r + Y_CG * g + Y_CB * b);
  assign y = 8'((ys + 16'd128) >> 8);
  assign d = $signed({2'b0, b}) - $signed({2'b0, y});
  assign e = $signed({2'b0, r}) - $signed({2'b0, y});
  assign ud = (d + 10'sd1) >>> 1;
  assign ud18 = {{8{ud[9]}}, ud};
  assign e18 = {{8{e[9]}}, e};
  assign p = VC18 * e18;
  assign u_sat = sat(ud18);
  assign v_sat = sat((p + 18'sd128) >>> 8);
  always_comb begin
    nxt = state;
    cap0 = 1'b0;
    cap1 = 1'b0;
    case (state)
      IDLE:   begin nxt = in_en ? HAVE0 : IDLE; cap0 = in_en; end
      HAVE0:  begin nxt = in_en ? OUT_U : HAVE0; cap1 = in_en; end
      OUT_U:  nxt = OUT_Y1;
      OUT_Y1: nxt = OUT_V;
      OUT_V:  nxt = OUT_Y2;
      OUT_Y2: begin nxt = in_en ? HAVE0 : IDLE; cap0 = in_en; end
      default: nxt = IDLE;
    endcase
    busy = state == OUT_U || state == OUT_Y1 || state == OUT_V;
    out_valid = busy || state == OUT_Y2;
    yuv_out = state == OUT_U  ? u  :
              state == OUT_Y1 ? y0 :
              state == OUT_V  ? v  :
              state == OUT_Y2 ? y1 : 8'h00;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      y0 <= '0;
      y1 <= '0;
      u <= '0;
      v <= '0;
    end else begin
      state <= nxt;
      if (cap0) begin
        y0 <= y;
        u <= u_sat;
        v <= v_sat;
      end
      if (cap1) y1 <= y;
    end
endmodule
